// File: rtl/cbd_pkg.sv
// Shared constants and FSM state encoding for the centered-binomial sampler.
package cbd_pkg;

    localparam int N      = 256;
    localparam int Q      = 3329;
    localparam int ETA    = 3;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int IDX_W  = $clog2(N);
    localparam int SMP_W  = 2 * ETA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cbd_coeff.sv
// Combinational CBD mapping: popcount of the a- and b-groups, difference
// folded into [0, Q-1] by adding Q when negative.
module cbd_coeff #(
    parameter int ETA    = 3,
    parameter int DATA_W = 12,
    parameter int Q      = 3329
) (
    input  logic [2*ETA-1:0]  s_data_i,
    output logic [DATA_W-1:0] coeff_o
);

    localparam int CW = $clog2(ETA + 1);

    logic [CW-1:0] a;
    logic [CW-1:0] b;

    // Count set bits in the low (a) and high (b) groups.
    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < ETA; i++) begin
            a = a + CW'(s_data_i[i]);
            b = b + CW'(s_data_i[ETA + i]);
        end
    end

    // a == b lands in the first branch, so zero is never reported as Q.
    always_comb begin
        coeff_o = '0;
        if (a >= b) begin
            coeff_o = DATA_W'(a - b);
        end else begin
            coeff_o = DATA_W'(Q) - DATA_W'(b - a);
        end
    end

endmodule

// File: rtl/cbd_sample_ctrl.sv
// Sampling controller: accepts N random samples, maps each to a coefficient
// and writes them to consecutive RAM addresses starting at a latched base.
//
// Stream handshake: a sample transfers on a rising edge where s_valid and
// s_ready are both high; s_ready is a pure function of state (high only in
// RUN) and never depends on s_valid. The producer may change s_data freely
// while s_valid is low.
module cbd_sample_ctrl
    import cbd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              s_valid,
    input  logic [SMP_W-1:0]  s_data,
    output logic              s_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   coeff;
    logic                hs;

    cbd_coeff #(
        .ETA    (ETA),
        .DATA_W (DATA_W),
        .Q      (Q)
    ) u_coeff (
        .s_data_i (s_data),
        .coeff_o  (coeff)
    );

    assign hs = s_valid & s_ready;

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One-stage write register fed by the accepted sample; address wraps
    // silently at the RAM size.
    always_comb begin
        wr_en_d   = hs;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (hs) begin
            wr_addr_d = base_q + ADDR_W'(idx_q);
            wr_data_d = coeff;
        end
    end

    // State, counter and base registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
        end
    end

    // RAM port-A output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // A write still sitting in the register during a reset cycle must not
    // reach the RAM.
    assign ram_en    = wr_en_q & rst_n;
    assign ram_we    = ram_en;
    assign ram_addr  = wr_addr_q;
    assign ram_din   = wr_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cbd_sample_ctrl.sv
// Self-checking bench for cbd_sample_ctrl: expected writes are queued as
// samples are accepted and compared as the RAM port shows them.
module tb_cbd_sample_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic        s_valid;
    logic [5:0]  s_data;
    logic        s_ready;
    logic        ram_en;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [11:0] ram_din;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    logic [21:0] exp_q[$];
    logic [9:0]  exp_base;
    logic [9:0]  exp_idx;
    logic [9:0]  exp_addr;
    logic [21:0] exp_e;
    int          wr_cnt;
    int          done_cnt;
    int          hs_cnt;
    logic        cur_hs;
    logic        prev_hs  = 1'b0;
    logic        prev_en  = 1'b0;
    logic        prev_rdy = 1'b0;

    logic [5:0]  tbl_d [6] = '{6'b000111, 6'b111000, 6'b000000, 6'b111111, 6'b011001, 6'b000011};
    logic [11:0] tbl_c [6] = '{12'd3, 12'd3326, 12'd0, 12'd0, 12'd3328, 12'd2};

    cbd_sample_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference mapping: known vectors from a table, otherwise popcount model.
    function automatic logic [11:0] exp_coeff(input logic [5:0] d);
        int a;
        int b;
        for (int i = 0; i < 6; i++) begin
            if (d == tbl_d[i]) return tbl_c[i];
        end
        a = $countones(d[2:0]);
        b = $countones(d[5:3]);
        if (a >= b) return 12'(a - b);
        return 12'(3329 - (b - a));
    endfunction

    // Scoreboard: compare writes, then queue the handshake of this cycle.
    always @(negedge clk) begin
        if (!rst_n) check("rst_wr_suppr", 32'(ram_en), 0);
        if (ram_en) begin
            wr_cnt++;
            check("we_eq_en", 32'(ram_we), 1);
            check("wr_latency", 32'(prev_hs), 1);
            check("wr_q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(exp_e[21:12]));
                check("wr_data", 32'(ram_din), 32'(exp_e[11:0]));
            end
        end
        if (done) begin
            done_cnt++;
            check("drain_last_wr", 32'(prev_en), 1);
            check("drain_ready_low", 32'(prev_rdy), 0);
            check("done_ready_low", 32'(s_ready), 0);
            check("done_busy", 32'(busy), 1);
            check("done_no_wr", 32'(ram_en), 0);
        end
        cur_hs = rst_n && s_valid && s_ready;
        if (cur_hs) begin
            exp_addr = exp_base + exp_idx;
            exp_q.push_back({exp_addr, exp_coeff(s_data)});
            exp_idx++;
            hs_cnt++;
        end
        prev_hs  = cur_hs;
        prev_en  = ram_en;
        prev_rdy = s_ready;
    end

    // pmode: 0 fixed 000111, 1 table cycle, 2 random.
    // vmode: 0 valid held, 1 toggle, 2 random.
    // opt:   0 plain, 1 stray starts mid-run and in DONE, 2 reset at idx 50.
    task automatic run_poly(input logic [9:0] base, input int pmode, input int vmode, input int opt);
        int cyc;
        wr_cnt   = 0;
        done_cnt = 0;
        hs_cnt   = 0;
        exp_idx  = '0;
        exp_base = base;
        check("idle_busy", 32'(busy), 0);
        check("idle_ready", 32'(s_ready), 0);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 10'($urandom_range(0, 1023));
        check("busy_after_start", 32'(busy), 1);
        check("ready_in_run", 32'(s_ready), 1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (opt == 2 && hs_cnt == 50) break;
            case (vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            case (pmode)
                0:       s_data = 6'b000111;
                1:       s_data = tbl_d[cyc % 6];
                default: s_data = 6'($urandom_range(0, 63));
            endcase
            if (opt == 1) start = (hs_cnt == 100);
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (opt == 2) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            check("abort_ram_en", 32'(ram_en), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_done", 32'(done), 0);
            check("abort_ready", 32'(s_ready), 0);
            check("abort_state", 32'(dbg_state), 0);
            check("abort_wr_cnt", 32'(wr_cnt), 49);
            check("abort_done_cnt", 32'(done_cnt), 0);
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1;
            check("abort_quiet", 32'(wr_cnt), 49);
        end else begin
            check("done_reached", 32'(done), 1);
            if (opt == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("post_done_busy", 32'(busy), 0);
            check("post_done_state", 32'(dbg_state), 0);
            check("post_done_pulse", 32'(done), 0);
            repeat (3) @(posedge clk);
            #1;
            check("wr_total", 32'(wr_cnt), 256);
            check("done_once", 32'(done_cnt), 1);
            check("q_drained", 32'(exp_q.size()), 0);
            check("stays_idle", 32'(dbg_state), 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        exp_base  = '0;
        exp_idx   = '0;
        wr_cnt    = 0;
        done_cnt  = 0;
        hs_cnt    = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_din", 32'(ram_din), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_state", 32'(dbg_state), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_poly(10'h100, 0, 0, 0);
        run_poly(10'h200, 1, 1, 0);
        run_poly(10'h3F0, 2, 2, 0);
        run_poly(10'h080, 2, 0, 1);
        run_poly(10'h010, 2, 0, 2);
        run_poly(10'h300, 1, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
